// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory read port, branch redirect
// input and the valid/ready instruction channel toward decode.
//   master : the fetch unit (drives imem_req/imem_addr and the decode channel)
//   slave  : the environment (memory, branch resolution, decoder)
interface instr_fetch_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32
) ();
  localparam int unsigned OPC_W = 6;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               dec_ready;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [OPC_W-1:0]   opcode;
  logic [ADDR_W-1:0]  pc_out;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, opcode, pc_out,
    input  imem_ack, imem_rdata, redirect, redirect_pc, dec_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, opcode, pc_out,
    output imem_ack, imem_rdata, redirect, redirect_pc, dec_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, issues one instruction-memory read at
// a time, registers the returned word and presents {opcode, instr, pc_out} to
// decode under valid/ready. Branch redirects discard in-flight or held work.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : instr_fetch_if.master (imem_req/addr/ack/rdata, redirect/redirect_pc,
//          dec_ready, instr_valid/instr/opcode/pc_out); all outputs registered
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic           clk,
  input  logic           rst,
  instr_fetch_if.master  bus
);
  localparam int unsigned OPC_W = 6;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2,
    FLUSH = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               req_q, req_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [OPC_W-1:0]   opcode_q, opcode_d;
  logic [ADDR_W-1:0]  pc_out_q, pc_out_d;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      opcode_q <= '0;
      pc_out_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      opcode_q <= opcode_d;
      pc_out_q <= pc_out_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_d    = req_q;
    addr_d   = addr_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    opcode_d = opcode_q;
    pc_out_d = pc_out_q;

    unique case (state_q)
      FETCH: begin
        if (bus.redirect) begin
          pc_d = bus.redirect_pc;
        end else begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (bus.imem_ack) begin
          req_d = 1'b0;
          if (bus.redirect) begin
            pc_d    = bus.redirect_pc;
            state_d = FETCH;
          end else begin
            instr_d  = bus.imem_rdata;
            opcode_d = bus.imem_rdata[INSTR_W-1 -: OPC_W];
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            state_d  = ISSUE;
          end
        end else if (bus.redirect) begin
          pc_d    = bus.redirect_pc;
          state_d = FLUSH;
        end
      end

      // Request is still outstanding at the old address; wait it out, then refetch.
      FLUSH: begin
        if (bus.redirect) begin
          pc_d = bus.redirect_pc;
        end
        if (bus.imem_ack) begin
          req_d   = 1'b0;
          state_d = FETCH;
        end
      end

      // Redirect wins over dec_ready: the held instruction is on a dead path.
      ISSUE: begin
        if (bus.redirect) begin
          valid_d  = 1'b0;
          opcode_d = '0;
          pc_d     = bus.redirect_pc;
          state_d  = FETCH;
        end else if (bus.dec_ready) begin
          valid_d  = 1'b0;
          opcode_d = '0;
          pc_d     = pc_q + ADDR_W'(PC_STEP);
          state_d  = FETCH;
        end
      end

      default: state_d = FETCH;
    endcase
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.opcode      = opcode_q;
  assign bus.pc_out      = pc_out_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a transaction-level model of the fetch unit is
// compared against the main instance every cycle; directed scenarios add
// literal expectations. A second instance with RESET_PC=0xFFFF_FFFC covers PC
// wrap and asynchronous reset in the middle of a request.
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_w = 1'b1;

  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_W(32), .INSTR_W(32)) bm ();
  instr_fetch_if #(.ADDR_W(32), .INSTR_W(32)) bw ();

  instr_fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .bus(bm)
  );

  instr_fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_w (
    .clk(clk), .rst(rst_w), .bus(bw)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory contents: opcode = word index + 1, low bits carry the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'hFFFF_FFFC) return 32'hFC00_0000;
    return {6'(a[7:2] + 6'd1), 26'(a >> 3)};
  endfunction

  // Memory responders: ack after ack_delay cycles of an open request.
  int ack_delay = 0;
  int req_age   = 0;
  always @(negedge clk) begin
    if (bm.imem_req) begin
      bm.imem_ack = (req_age >= ack_delay);
      req_age++;
    end else begin
      bm.imem_ack = 1'b0;
      req_age = 0;
    end
    bm.imem_rdata = mem_word(bm.imem_addr);
  end

  bit ack_en_w    = 1'b1;
  bit force_ack_w = 1'b0;
  always @(negedge clk) begin
    bw.imem_ack   = force_ack_w | (ack_en_w & bw.imem_req);
    bw.imem_rdata = mem_word(bw.imem_addr);
  end

  // Transaction-level model of the main instance.
  logic        m_req, m_valid, m_kill;
  logic [31:0] m_addr, m_pc, m_instr, m_pc_out;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_req = 1'b0; m_valid = 1'b0; m_kill = 1'b0;
      m_addr = 32'h0; m_pc = 32'h0; m_instr = 32'h0; m_pc_out = 32'h0;
    end else if (m_valid) begin
      if (bm.redirect) begin
        m_valid = 1'b0; m_pc = bm.redirect_pc;
      end else if (bm.dec_ready) begin
        m_valid = 1'b0; m_pc = m_pc_out + 32'd4;
      end
    end else if (m_req) begin
      if (bm.redirect) m_pc = bm.redirect_pc;
      if (bm.imem_ack) begin
        m_req = 1'b0;
        if (!m_kill && !bm.redirect) begin
          m_valid = 1'b1; m_instr = mem_word(m_addr); m_pc_out = m_addr;
        end
        m_kill = 1'b0;
      end else if (bm.redirect) begin
        m_kill = 1'b1;
      end
    end else begin
      if (bm.redirect) m_pc = bm.redirect_pc;
      else begin m_req = 1'b1; m_addr = m_pc; end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("req",    64'(bm.imem_req),    64'(m_req));
    chk("addr",   64'(bm.imem_addr),   64'(m_addr));
    chk("valid",  64'(bm.instr_valid), 64'(m_valid));
    chk("opcode", 64'(bm.opcode),      64'(m_valid ? m_instr[31:26] : 6'd0));
    chk("instr",  64'(bm.instr),       64'(m_instr));
    chk("pc_out", 64'(bm.pc_out),      64'(m_pc_out));
  end

  // Instructions actually taken by decode (redirect drops the held one).
  int n_acc = 0;
  always @(posedge clk)
    if (!rst && bm.instr_valid && bm.dec_ready && !bm.redirect) n_acc++;

  task automatic wait_new_req(input bit w, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(w ? bw.imem_req : bm.imem_req) && n < 20);
    chk("req_timeout", 64'(w ? bw.imem_req : bm.imem_req), 64'd1);
  endtask

  int n;

  initial begin
    bm.redirect = 1'b0; bm.redirect_pc = 32'h0; bm.dec_ready = 1'b1;
    bm.imem_ack = 1'b0; bm.imem_rdata = 32'h0;
    bw.redirect = 1'b0; bw.redirect_pc = 32'h0; bw.dec_ready = 1'b1;
    bw.imem_ack = 1'b0; bw.imem_rdata = 32'h0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_req",    64'(bm.imem_req),    64'd0);
    chk("rst_addr",   64'(bm.imem_addr),   64'h0);
    chk("rst_valid",  64'(bm.instr_valid), 64'd0);
    chk("rst_opcode", 64'(bm.opcode),      64'd0);
    chk("rst_instr",  64'(bm.instr),       64'h0);
    chk("rst_pc_out", 64'(bm.pc_out),      64'h0);
    rst = 1'b0;

    // 1. linear fetch, same-cycle ack, decode always ready
    wait_new_req(1'b0, n);
    chk("t1_first_lat", 64'(n), 64'd1);
    chk("t1_addr0", 64'(bm.imem_addr), 64'h0);
    @(negedge clk);
    chk("t1_op0", 64'(bm.opcode), 64'h01);
    chk("t1_instr0", 64'(bm.instr), 64'h0400_0000);
    wait_new_req(1'b0, n);
    chk("t1_gap", 64'(n), 64'd2);
    chk("t1_addr4", 64'(bm.imem_addr), 64'h4);
    @(negedge clk);
    chk("t1_op1", 64'(bm.opcode), 64'h02);
    chk("t1_instr1", 64'(bm.instr), 64'h0800_0000);
    wait_new_req(1'b0, n);
    chk("t1_addr8", 64'(bm.imem_addr), 64'h8);

    // 2. decode stall for 5 cycles in ISSUE
    bm.dec_ready = 1'b0;
    @(negedge clk);
    chk("t2_valid", 64'(bm.instr_valid), 64'd1);
    repeat (5) begin
      @(negedge clk);
      chk("t2_hold_valid", 64'(bm.instr_valid), 64'd1);
      chk("t2_hold_pc",    64'(bm.pc_out),      64'h8);
      chk("t2_hold_op",    64'(bm.opcode),      64'h03);
      chk("t2_hold_req",   64'(bm.imem_req),    64'd0);
    end
    bm.dec_ready = 1'b1;
    wait_new_req(1'b0, n);
    chk("t2_next_addr", 64'(bm.imem_addr), 64'hC);

    // 3. redirect while holding an instruction with dec_ready=1
    @(negedge clk);
    chk("t3_valid", 64'(bm.instr_valid), 64'd1);
    bm.redirect = 1'b1; bm.redirect_pc = 32'h100;
    ack_delay = 3;
    @(negedge clk);
    bm.redirect = 1'b0;
    chk("t3_dropped", 64'(bm.instr_valid), 64'd0);
    chk("t3_op_zero", 64'(bm.opcode), 64'd0);
    wait_new_req(1'b0, n);
    chk("t3_target", 64'(bm.imem_addr), 64'h100);
    chk("t3_model_addr", 64'(m_addr), 64'h100);

    // 4. redirect while waiting; ack arrives 3 cycles later
    bm.redirect = 1'b1; bm.redirect_pc = 32'h200;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bm.redirect = 1'b0;
      if (!bm.imem_req) break;
      chk("t4_addr_held", 64'(bm.imem_addr), 64'h100);
      chk("t4_no_valid",  64'(bm.instr_valid), 64'd0);
    end
    chk("t4_req_done", 64'(bm.imem_req), 64'd0);
    chk("t4_no_valid_after", 64'(bm.instr_valid), 64'd0);
    ack_delay = 0;
    wait_new_req(1'b0, n);
    chk("t4_target", 64'(bm.imem_addr), 64'h200);
    wait_new_req(1'b0, n);
    chk("t4_seq_lat", 64'(n), 64'd3);
    chk("t4_seq_addr", 64'(bm.imem_addr), 64'h204);

    // 5. redirect coincident with imem_ack
    bm.redirect = 1'b1; bm.redirect_pc = 32'h300;
    @(negedge clk);
    bm.redirect = 1'b0;
    chk("t5_no_valid", 64'(bm.instr_valid), 64'd0);
    chk("t5_req_low",  64'(bm.imem_req), 64'd0);
    wait_new_req(1'b0, n);
    chk("t5_gap", 64'(n), 64'd1);
    chk("t5_target", 64'(bm.imem_addr), 64'h300);
    @(negedge clk);
    chk("t5_pc_out", 64'(bm.pc_out), 64'h300);
    chk("t5_model_pc_out", 64'(m_pc_out), 64'h300);
    @(negedge clk);
    chk("accepted", 64'(n_acc), 64'd5);

    // 6. wrap instance: PC wrap and async reset during WAIT
    rst_w = 1'b0;
    wait_new_req(1'b1, n);
    chk("t6_addr_top", 64'(bw.imem_addr), 64'hFFFF_FFFC);
    @(negedge clk);
    chk("t6_valid",  64'(bw.instr_valid), 64'd1);
    chk("t6_opcode", 64'(bw.opcode), 64'h3F);
    chk("t6_pc_out", 64'(bw.pc_out), 64'hFFFF_FFFC);
    ack_en_w = 1'b0;
    wait_new_req(1'b1, n);
    chk("t6_wrap_addr", 64'(bw.imem_addr), 64'h0);
    #2 rst_w = 1'b1;
    #1;
    chk("t6_async_req",    64'(bw.imem_req),    64'd0);
    chk("t6_async_opcode", 64'(bw.opcode),      64'd0);
    chk("t6_async_valid",  64'(bw.instr_valid), 64'd0);
    chk("t6_async_addr",   64'(bw.imem_addr),   64'hFFFF_FFFC);
    force_ack_w = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("t6_late_ack_valid", 64'(bw.instr_valid), 64'd0);
      chk("t6_late_ack_req",   64'(bw.imem_req),    64'd0);
    end
    force_ack_w = 1'b0;
    ack_en_w = 1'b1;
    rst_w = 1'b0;
    wait_new_req(1'b1, n);
    chk("t6_restart_addr", 64'(bw.imem_addr), 64'hFFFF_FFFC);

    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
